// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder -- pipelined, parametrised carry-lookahead adder.
//
// A WIDTH-bit add is cut into STAGES segments of SEG = WIDTH/STAGES bits;
// stage k resolves bits [k*SEG +: SEG] one clock after stage k-1. Each
// segment is a two-level CLA: 4-bit groups feeding a group-level lookahead.
// Operand bits still to be added ride along in the pipe (input-side skew),
// shrinking by SEG bits every stage.
//
// Optional feature: define CLA_PIPE_SUB_EN to add port i_sub. When 1 the
// block adds ~b with a forced carry-in of 1 (s = a - b, c_out=1 = no borrow).
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_in_valid/o_in_ready  operand handshake (i_a, i_b, i_c_in [, i_sub])
//   o_out_valid/i_out_ready result handshake (o_s, o_c_out, o_P, o_G, o_ovf)
//   o_P / o_G           whole-word propagate / generate (G ignores c_in)
//   o_ovf               signed overflow (carry into MSB xor carry out)

// Flattened lookahead over N (p,g) pairs: carry into every position plus
// block propagate/generate. Carries and P/G live in separate processes so
// the block P/G never appears to depend on the carry-in.
module cla_pipe_la #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_p,
   input  logic [N-1:0] i_g,
   input  logic         i_c,
   output logic [N-1:0] o_c,
   output logic         o_P,
   output logic         o_G
);
   assign o_P = &i_p;

   // c_i = c0&p0..p(i-1) | OR_j g_j&p(j+1)..p(i-1): sum of products, no ripple
   always_comb begin : la_carry
      logic t, c;
      t   = 1'b0;
      c   = 1'b0;
      o_c = '0;
      for (int i = 0; i < N; i++) begin
         t = i_c;
         for (int m = 0; m < i; m++) t = t & i_p[m];
         c = t;
         for (int j = 0; j < i; j++) begin
            t = i_g[j];
            for (int m = j + 1; m < i; m++) t = t & i_p[m];
            c = c | t;
         end
         o_c[i] = c;
      end
   end

   always_comb begin : la_gen
      logic t;
      t   = 1'b0;
      o_G = 1'b0;
      for (int j = 0; j < N; j++) begin
         t = i_g[j];
         for (int m = j + 1; m < N; m++) t = t & i_p[m];
         o_G = o_G | t;
      end
   end
endmodule

// One SEG-bit segment: 4-bit CLA groups under a group-level lookahead unit.
module cla_pipe_seg #(
   parameter int SEG = 4
) (
   input  logic [SEG-1:0] i_a,
   input  logic [SEG-1:0] i_b,
   input  logic           i_c,
   output logic [SEG-1:0] o_s,
   output logic           o_c,
   output logic           o_P,
   output logic           o_G
);
   localparam int NG = SEG / 4;

   logic [SEG-1:0] w_p, w_g, w_bc;
   logic [NG-1:0]  w_gp, w_gg, w_gc;
   logic           w_sp, w_sg;

   assign w_p = i_a ^ i_b;
   assign w_g = i_a & i_b;

   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      cla_pipe_la #(.N(4)) u_bit (
         .i_p(w_p[4*gi +: 4]), .i_g(w_g[4*gi +: 4]), .i_c(w_gc[gi]),
         .o_c(w_bc[4*gi +: 4]), .o_P(w_gp[gi]), .o_G(w_gg[gi]));
   end

   cla_pipe_la #(.N(NG)) u_grp (
      .i_p(w_gp), .i_g(w_gg), .i_c(i_c),
      .o_c(w_gc), .o_P(w_sp), .o_G(w_sg));

   assign o_s = w_p ^ w_bc;
   assign o_P = w_sp;
   assign o_G = w_sg;
   assign o_c = w_sg | (w_sp & i_c);
endmodule

module cla_pipe_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_c_in,
`ifdef CLA_PIPE_SUB_EN
   input  logic             i_sub,
`endif
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_s,
   output logic             o_c_out,
   output logic             o_P,
   output logic             o_G,
   output logic             o_ovf
);
   localparam int SEG = WIDTH / STAGES;

   // Pending operand bits are packed back to back: stage k keeps the
   // WIDTH-(k+1)*SEG bits not yet added, starting at op_off(k).
   function automatic int op_off(input int k);
      return k * WIDTH - SEG * k * (k + 1) / 2;
   endfunction
   localparam int OPT = op_off(STAGES - 1);
   localparam int OPW = (OPT > 0) ? OPT : 1;

   if (STAGES < 1 || (WIDTH % (4 * STAGES)) != 0) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must be a multiple of 4*STAGES");
   end

   logic                          w_adv, w_acc, r_init, w_c_eff;
   logic [WIDTH-1:0]              w_b_eff;
   logic [STAGES-1:0]             r_vld, w_vi;
   logic [STAGES-1:0][WIDTH-1:0]  r_s, w_si, w_snx;
   logic [STAGES-1:0]             r_c, r_P, r_G, w_ci, w_Pi, w_Gi;
   logic [STAGES-1:0]             w_cnx, w_Pnx, w_Gnx, w_segP, w_segG;
   logic [STAGES-1:0][SEG-1:0]    w_sega, w_segb, w_segs;
   logic [OPW-1:0]                r_opa, r_opb, w_opa_nx, w_opb_nx;
   logic                          r_ovf, w_ovf;

`ifdef CLA_PIPE_SUB_EN
   assign w_b_eff = i_sub ? ~i_b : i_b;
   assign w_c_eff = i_c_in | i_sub;
`else
   assign w_b_eff = i_b;
   assign w_c_eff = i_c_in;
`endif

   // Whole-pipe stall: everything moves or nothing does.
   assign w_adv      = i_out_ready | ~r_vld[STAGES-1];
   assign o_in_ready = w_adv & r_init;
   assign w_acc      = i_in_valid & o_in_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      if (k == 0) begin : g_in
         assign w_vi[0]   = w_acc;
         assign w_si[0]   = '0;
         assign w_ci[0]   = w_c_eff;
         assign w_Pi[0]   = 1'b1;
         assign w_Gi[0]   = 1'b0;
         assign w_sega[0] = i_a[SEG-1:0];
         assign w_segb[0] = w_b_eff[SEG-1:0];
      end else begin : g_mid
         assign w_vi[k]   = r_vld[k-1];
         assign w_si[k]   = r_s[k-1];
         assign w_ci[k]   = r_c[k-1];
         assign w_Pi[k]   = r_P[k-1];
         assign w_Gi[k]   = r_G[k-1];
         assign w_sega[k] = r_opa[op_off(k-1) +: SEG];
         assign w_segb[k] = r_opb[op_off(k-1) +: SEG];
      end

      if (k < STAGES - 1) begin : g_fwd
         localparam int REM = WIDTH - (k + 1) * SEG;
         if (k == 0) begin : g_f0
            assign w_opa_nx[0 +: REM] = i_a[WIDTH-1:SEG];
            assign w_opb_nx[0 +: REM] = w_b_eff[WIDTH-1:SEG];
         end else begin : g_fk
            assign w_opa_nx[op_off(k) +: REM] = r_opa[op_off(k-1) + SEG +: REM];
            assign w_opb_nx[op_off(k) +: REM] = r_opb[op_off(k-1) + SEG +: REM];
         end
      end

      cla_pipe_seg #(.SEG(SEG)) u_seg (
         .i_a(w_sega[k]), .i_b(w_segb[k]), .i_c(w_ci[k]),
         .o_s(w_segs[k]), .o_c(w_cnx[k]), .o_P(w_segP[k]), .o_G(w_segG[k]));

      // Bits at and above k*SEG are still zero, so OR inserts the segment.
      assign w_snx[k] = w_si[k] | (WIDTH'(w_segs[k]) << (k * SEG));
   end

   assign w_Pnx = w_Pi & w_segP;
   assign w_Gnx = w_segG | (w_segP & w_Gi);
   // a^b^s at the MSB recovers the carry into the MSB.
   assign w_ovf = w_sega[STAGES-1][SEG-1] ^ w_segb[STAGES-1][SEG-1]
                ^ w_segs[STAGES-1][SEG-1] ^ w_cnx[STAGES-1];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_init <= 1'b0;
         r_vld  <= '0;
         r_s    <= '0;
         r_c    <= '0;
         r_P    <= '0;
         r_G    <= '0;
         r_ovf  <= 1'b0;
         r_opa  <= '0;
         r_opb  <= '0;
      end else begin
         r_init <= 1'b1;
         if (w_adv) begin
            r_vld <= w_vi;
            r_s   <= w_snx;
            r_c   <= w_cnx;
            r_P   <= w_Pnx;
            r_G   <= w_Gnx;
            r_ovf <= w_ovf;
            r_opa <= w_opa_nx;
            r_opb <= w_opb_nx;
         end
      end
   end

   assign o_out_valid = r_vld[STAGES-1];
   assign o_s         = r_s[STAGES-1];
   assign o_c_out     = r_c[STAGES-1];
   assign o_P         = r_P[STAGES-1];
   assign o_G         = r_G[STAGES-1];
   assign o_ovf       = r_ovf;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder (WIDTH=16, STAGES=4): directed corner cases,
// back-to-back random traffic, mid-flight reset and random backpressure,
// checked against a behavioural model through an expected-result queue.
module tb_cla_pipe_adder;
   localparam int W = 16;
   localparam int S = 4;

   logic         clk = 1'b0, rst = 1'b1;
   logic         in_valid = 1'b0, out_ready = 1'b1, c_in = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         in_ready, out_valid, c_out, P, G, ovf;
   logic [W-1:0] s;
`ifdef CLA_PIPE_SUB_EN
   logic         sub = 1'b0;
`endif

   cla_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_a(a), .i_b(b), .i_c_in(c_in),
`ifdef CLA_PIPE_SUB_EN
      .i_sub(sub),
`endif
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_s(s),
      .o_c_out(c_out), .o_P(P), .o_G(G), .o_ovf(ovf));

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0, cyc = 0, since_rst = 0;
   bit lat_chk = 1'b0, bp = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) since_rst <= rst ? 0 : since_rst + 1;

   typedef struct {
      logic [W-1:0] s;
      logic c, P, G, ovf;
      int   acc;
   } exp_t;
   exp_t q[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      assert (act === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, expv);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sb);
      exp_t e;
      logic [W-1:0] ye;
      logic [W:0]   sum, gsum;
      ye    = sb ? ~y : y;
      sum   = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ci | sb};
      gsum  = {1'b0, x} + {1'b0, ye};
      e.s   = sum[W-1:0];
      e.c   = sum[W];
      e.P   = &(x ^ ye);
      e.G   = gsum[W];
      e.ovf = (x[W-1] == ye[W-1]) && (sum[W-1] != x[W-1]);
      e.acc = 0;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (bp) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Present one beat, hold it until accepted, then queue its expected result.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic sb);
      exp_t e;
      int   waitc;
      a = x; b = y; c_in = ci; in_valid = 1'b1;
`ifdef CLA_PIPE_SUB_EN
      sub = sb;
`endif
      waitc = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waitc++;
         if (waitc > 200) begin
            chk("accept_timeout", in_ready, 1);
            break;
         end
         tick();
      end
      e = model(x, y, ci, sb);
      e.acc = cyc;
      q.push_back(e);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Output monitor: scoreboard pop, stall stability, ready equation.
   initial begin : mon
      exp_t e;
      bit   prev_stall;
      logic [W+3:0] prev_o;
      prev_stall = 1'b0;
      prev_o = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (since_rst >= 1) chk("in_ready_eq", in_ready, out_ready || !out_valid);
            if (prev_stall) chk("stall_hold", {out_valid, s, c_out, P, G, ovf}, {1'b1, prev_o});
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("spurious_out", out_valid, 0);
               end else begin
                  e = q.pop_front();
                  chk("result", {s, c_out, P, G, ovf}, {e.s, e.c, e.P, e.G, e.ovf});
                  if (lat_chk) chk("latency", cyc - e.acc, S);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_o = {s, c_out, P, G, ovf};
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [W-1:0] da[7] = '{16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000, 16'h5555, 16'h1234};
      logic [W-1:0] db[7] = '{16'h0001, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'hAAAA, 16'h4321};
      logic         dc[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int t;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {out_valid, s, c_out, P, G, ovf}, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_rst", in_ready, 1);
      @(posedge clk); #1;

      // Directed corners with out_ready held high
      lat_chk = 1'b1;
      for (int i = 0; i < 7; i++) send(da[i], db[i], dc[i], 1'b0);
      idle(6);
`ifdef CLA_PIPE_SUB_EN
      send(16'h0003, 16'h0005, 1'b0, 1'b1);
      send(16'h0005, 16'h0003, 1'b0, 1'b1);
      idle(6);
`endif

      // Back-to-back random beats
      for (int i = 0; i < 100; i++)
         send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      idle(6);

      // Reset with three beats in flight
      send(16'h1111, 16'h2222, 1'b0, 1'b0);
      send(16'h3333, 16'h4444, 1'b1, 1'b0);
      send(16'h5555, 16'h6666, 1'b0, 1'b0);
      #2 rst = 1'b1;
      q.delete();
      @(negedge clk);
      chk("rst_flush", {out_valid, s, c_out, P, G, ovf}, 0);
      @(posedge clk); #1 rst = 1'b0;
      idle(8);
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      idle(6);

      // Random backpressure and random input gaps
      lat_chk = 1'b0;
      bp = 1'b1;
      for (int i = 0; i < 150; i++) begin
`ifdef CLA_PIPE_SUB_EN
         send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
         send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
`endif
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      bp = 1'b0;
      out_ready = 1'b1;
      t = 0;
      while (q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      @(negedge clk);
      chk("drain_left", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
